// File: rtl/sw_debouncer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sw_debouncer_if                                                        |
// | Raw switch input and debounced outputs of the switch debouncer.        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface sw_debouncer_if #(
  parameter int N_SW = 4
);
  logic [N_SW-1:0] i_sw_raw;
  logic [N_SW-1:0] o_sw;
  logic [N_SW-1:0] o_sw_rise;
  logic [N_SW-1:0] o_sw_fall;
  logic            o_stable;

  modport master (
    output i_sw_raw,
    input  o_sw,
    input  o_sw_rise,
    input  o_sw_fall,
    input  o_stable
  );

  modport slave (
    input  i_sw_raw,
    output o_sw,
    output o_sw_rise,
    output o_sw_fall,
    output o_stable
  );
endinterface
`default_nettype wire

// File: rtl/sw_debouncer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sw_debouncer                                                           |
// | Two-flop synchronizer plus per-bit stability counter for slide         |
// | switches; publishes level, rise/fall pulses and an all-settled flag.  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module sw_debouncer #(
  parameter int N_SW       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STABLE_CNT = 4
) (
  input  wire logic      clock,
  input  wire logic      i_reset,
  sw_debouncer_if.slave  sw_if
);

  localparam logic [DATA_WIDTH-1:0] c_CNT_LAST = DATA_WIDTH'(STABLE_CNT - 1);

  logic [N_SW-1:0]       s1_q, s1_d;
  logic [N_SW-1:0]       s2_q, s2_d;
  logic [N_SW-1:0]       sw_q, sw_d;
  logic [N_SW-1:0]       rise_q, rise_d;
  logic [N_SW-1:0]       fall_q, fall_d;
  logic [DATA_WIDTH-1:0] cnt_q [N_SW];
  logic [DATA_WIDTH-1:0] cnt_d [N_SW];
  logic [1:0]            vld_q, vld_d;
  logic                  stable_q, stable_d;
  logic [N_SW-1:0]       bit_ok;

  always_comb begin
    s1_d     = sw_if.i_sw_raw;
    s2_d     = s1_q;
    // vld_q[1] marks the synchronizer as holding real samples after reset
    vld_d    = {vld_q[0], 1'b1};
    sw_d     = sw_q;
    rise_d   = '0;
    fall_d   = '0;
    bit_ok   = '0;
    for (int i = 0; i < N_SW; i++) begin
      cnt_d[i]  = '0;
      bit_ok[i] = (s2_q[i] == sw_q[i]) && (cnt_q[i] == '0);
      if (s2_q[i] != sw_q[i]) begin
        if (cnt_q[i] == c_CNT_LAST) begin
          sw_d[i]   = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    stable_d = vld_q[1] && (&bit_ok);
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      sw_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      vld_q    <= '0;
      stable_q <= 1'b0;
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      sw_q     <= sw_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      vld_q    <= vld_d;
      stable_q <= stable_d;
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_if.o_sw      = sw_q;
  assign sw_if.o_sw_rise = rise_q;
  assign sw_if.o_sw_fall = fall_q;
  assign sw_if.o_stable  = stable_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_debouncer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sw_debouncer                                                        |
// | Directed bench for sw_debouncer with hand-computed expectations.      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_sw_debouncer;

  logic clock;
  logic i_reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [3:0] acc_rise;
  logic [3:0] acc_fall;
  logic       sw_moved;

  sw_debouncer_if #(.N_SW(4)) sw_if ();

  sw_debouncer #(
    .N_SW       (4),
    .DATA_WIDTH (32),
    .STABLE_CNT (4)
  ) u_dut (
    .clock   (clock),
    .i_reset (i_reset),
    .sw_if   (sw_if)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle 1 ns past it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    i_reset = 1'b1;
    sw_if.i_sw_raw = 4'b0000;
    repeat (3) tick();
    check("rst_sw",     {28'd0, sw_if.o_sw},      32'h0);
    check("rst_rise",   {28'd0, sw_if.o_sw_rise}, 32'h0);
    check("rst_fall",   {28'd0, sw_if.o_sw_fall}, 32'h0);
    check("rst_stable", {31'd0, sw_if.o_stable},  32'h0);

    // Release with raw all zero: stable from the third edge
    i_reset = 1'b0;
    tick();
    check("zero_e1_stable", {31'd0, sw_if.o_stable}, 32'h0);
    tick();
    check("zero_e2_stable", {31'd0, sw_if.o_stable}, 32'h0);
    tick();
    check("zero_e3_stable", {31'd0, sw_if.o_stable}, 32'h1);
    check("zero_e3_sw",     {28'd0, sw_if.o_sw},     32'h0);

    // Raw 1001 held through reset
    i_reset = 1'b1;
    sw_if.i_sw_raw = 4'b1001;
    repeat (2) tick();
    i_reset = 1'b0;
    repeat (5) tick();
    check("hold_e5_sw",     {28'd0, sw_if.o_sw},     32'h0);
    check("hold_e5_stable", {31'd0, sw_if.o_stable}, 32'h0);
    tick();
    check("hold_e6_sw",   {28'd0, sw_if.o_sw},      32'h9);
    check("hold_e6_rise", {28'd0, sw_if.o_sw_rise}, 32'h9);
    tick();
    check("hold_e7_rise",   {28'd0, sw_if.o_sw_rise}, 32'h0);
    check("hold_e7_stable", {31'd0, sw_if.o_stable},  32'h1);

    // raw[3] falls
    sw_if.i_sw_raw = 4'b0001;
    repeat (5) tick();
    check("fall_e5_sw", {28'd0, sw_if.o_sw}, 32'h9);
    tick();
    check("fall_e6_sw",   {28'd0, sw_if.o_sw},      32'h1);
    check("fall_e6_fall", {28'd0, sw_if.o_sw_fall}, 32'h8);
    check("fall_e6_rise", {28'd0, sw_if.o_sw_rise}, 32'h0);
    tick();
    check("fall_e7_fall",   {28'd0, sw_if.o_sw_fall}, 32'h0);
    check("fall_e7_stable", {31'd0, sw_if.o_stable},  32'h1);

    // Three-clock glitch on raw[0]
    acc_rise = '0;
    acc_fall = '0;
    sw_moved = 1'b0;
    sw_if.i_sw_raw = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) sw_if.i_sw_raw = 4'b0001;
      tick();
      acc_rise |= sw_if.o_sw_rise;
      acc_fall |= sw_if.o_sw_fall;
      if (sw_if.o_sw != 4'b0001) sw_moved = 1'b1;
      if (k == 3) check("glitch_e3_stable", {31'd0, sw_if.o_stable}, 32'h0);
      if (k == 7) check("glitch_e7_stable", {31'd0, sw_if.o_stable}, 32'h1);
    end
    check("glitch_sw_moved", {31'd0, sw_moved}, 32'h0);
    check("glitch_rise",     {28'd0, acc_rise}, 32'h0);
    check("glitch_fall",     {28'd0, acc_fall}, 32'h0);

    // Preset bits[2:1] to 10, then change to 01 with bit 2 bouncing once
    sw_if.i_sw_raw = 4'b0101;
    repeat (8) tick();
    check("pre_sw", {28'd0, sw_if.o_sw}, 32'h5);
    sw_if.i_sw_raw = 4'b0011;
    tick();
    sw_if.i_sw_raw = 4'b0111;
    tick();
    sw_if.i_sw_raw = 4'b0011;
    repeat (3) tick();
    check("multi_e5_sw", {28'd0, sw_if.o_sw}, 32'h5);
    tick();
    check("multi_e6_sw",   {28'd0, sw_if.o_sw},      32'h7);
    check("multi_e6_rise", {28'd0, sw_if.o_sw_rise}, 32'h2);
    check("multi_e6_fall", {28'd0, sw_if.o_sw_fall}, 32'h0);
    tick();
    check("multi_e7_sw",   {28'd0, sw_if.o_sw},      32'h7);
    check("multi_e7_rise", {28'd0, sw_if.o_sw_rise}, 32'h0);
    tick();
    check("multi_e8_sw",   {28'd0, sw_if.o_sw},      32'h3);
    check("multi_e8_fall", {28'd0, sw_if.o_sw_fall}, 32'h4);
    check("multi_e8_rise", {28'd0, sw_if.o_sw_rise}, 32'h0);
    tick();
    check("multi_e9_fall", {28'd0, sw_if.o_sw_fall}, 32'h0);

    // Asynchronous reset while bit 3 is pending with cnt = 2
    sw_if.i_sw_raw = 4'b1011;
    repeat (4) tick();
    #4;
    i_reset = 1'b1;
    #1;
    check("async_sw",     {28'd0, sw_if.o_sw},     32'h0);
    check("async_stable", {31'd0, sw_if.o_stable}, 32'h0);
    repeat (2) tick();
    i_reset = 1'b0;
    repeat (5) tick();
    check("rel_e5_sw", {28'd0, sw_if.o_sw}, 32'h0);
    tick();
    check("rel_e6_sw",   {28'd0, sw_if.o_sw},      32'hB);
    check("rel_e6_rise", {28'd0, sw_if.o_sw_rise}, 32'hB);
    tick();
    check("rel_e7_rise",   {28'd0, sw_if.o_sw_rise}, 32'h0);
    check("rel_e7_stable", {31'd0, sw_if.o_stable},  32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
